float_mul_pipe: RTL and testbench

- Pipelined IEEE-754 binary32 multiplier, 3 stages.
- Sits directly upstream of the float accumulator unit; its out0 feeds the accumulator's in0, forming a multiply-accumulate datapath.
- Versat-style control: run starts a new computation, running gates pipeline advance.
- Flush-to-zero for denormals; round-to-nearest-even selectable at compile time.

---
 rtl/float_pkg.sv | 9 +
 rtl/float_unpack.sv | 16 +
 rtl/float_mul_pipe.sv | 105 ++++++++++
 tb/tb_float_mul_pipe.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// float_pkg: binary32 field widths, special encodings and operand classes shared by the float units.
package float_pkg;
   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;
   localparam int FP32_BIAS = 127;
   localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
   localparam logic [7:0] FP32_INF_EXP = 8'hFF;
   typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;
endpackage

// File: rtl/float_unpack.sv
// float_unpack: splits a binary32 into sign, exponent, hidden-1 mantissa and class; denormals read as zero.
module float_unpack
   import float_pkg::*;
(
   input  logic [31:0]           x,
   output logic                  sign,
   output logic [FP32_EXP_W-1:0] exp,
   output logic [FP32_MAN_W:0]   man,
   output fp_class_t             cls
);
   assign sign = x[31];
   assign exp = x[30:23];
   assign man = (exp == '0) ? '0 : {1'b1, x[22:0]};
   assign cls = (exp == '0) ? ZERO :
                (exp == FP32_INF_EXP) ? ((x[22:0] == '0) ? INF : NAN) : NORMAL;
endmodule

// File: rtl/float_mul_pipe.sv
// float_mul_pipe: 3-stage binary32 multiplier with run/running control, flush-to-zero and sticky flags.
// FLOAT_MUL_PIPE_RNE_EN selects round-to-nearest-even; otherwise results are truncated.
module float_mul_pipe
   import float_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              running,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] out0,
   output logic [2:0]        flags
);
   if (DATA_W != 32 || LATENCY != 3) begin : g_bad_cfg
      $error("float_mul_pipe supports only DATA_W=32, LATENCY=3");
   end
   logic a_sign, b_sign;
   logic [FP32_EXP_W-1:0] a_exp, b_exp;
   logic [FP32_MAN_W:0] a_man, b_man;
   fp_class_t a_cls, b_cls;
   float_unpack u_unpack_a (.x(in0), .sign(a_sign), .exp(a_exp), .man(a_man), .cls(a_cls));
   float_unpack u_unpack_b (.x(in1), .sign(b_sign), .exp(b_exp), .man(b_man), .cls(b_cls));
   logic s1_sign, s2_sign;
   logic signed [9:0] s1_exp, s2_exp;
   logic [23:0] s1_ma, s1_mb;
   logic [47:0] s2_prod;
   fp_class_t s1_ca, s1_cb, s2_ca, s2_cb;
   logic norm;
   logic [22:0] frac_t, frac;
   logic signed [9:0] e_n, e_r;
   logic is_nan, is_inf, is_zero, ovf, unf;
   logic [31:0] res;
   logic [2:0] ev;
`ifdef FLOAT_MUL_PIPE_RNE_EN
   logic guard, sticky;
   logic [23:0] rnd;
`else
   logic unused_lo;
`endif
   always_comb begin
      norm = s2_prod[47];
      frac_t = norm ? s2_prod[46:24] : s2_prod[45:23];
      e_n = s2_exp + 10'(norm);
`ifdef FLOAT_MUL_PIPE_RNE_EN
      guard = norm ? s2_prod[23] : s2_prod[22];
      sticky = norm ? |s2_prod[22:0] : |s2_prod[21:0];
      // a carry out of the fraction leaves it all-zero, which is the correct 1.0 x 2^(e+1)
      rnd = {1'b0, frac_t} + 24'(guard & (sticky | frac_t[0]));
      frac = rnd[22:0];
      e_r = e_n + 10'(rnd[23]);
`else
      unused_lo = ^s2_prod[22:0];
      frac = frac_t;
      e_r = e_n;
`endif
      is_nan = s2_ca == NAN || s2_cb == NAN || (s2_ca == ZERO && s2_cb == INF) ||
               (s2_ca == INF && s2_cb == ZERO);
      is_inf = s2_ca == INF || s2_cb == INF;
      is_zero = s2_ca == ZERO || s2_cb == ZERO;
      ovf = e_r >= 10'sd255;
      unf = e_r <= 10'sd0;
      res = is_nan ? FP32_QNAN :
            is_inf ? {s2_sign, FP32_INF_EXP, 23'h0} :
            is_zero ? {s2_sign, 31'h0} :
            ovf ? {s2_sign, FP32_INF_EXP, 23'h0} :
            unf ? {s2_sign, 31'h0} : {s2_sign, e_r[7:0], frac};
      ev = {is_nan, !is_nan && !is_inf && !is_zero && ovf,
            !is_nan && !is_inf && !is_zero && !ovf && unf};
   end
   always_ff @(posedge clk) begin
      if (rst || run) begin
         s1_sign <= 1'b0;
         s1_exp <= '0;
         s1_ma <= '0;
         s1_mb <= '0;
         s1_ca <= ZERO;
         s1_cb <= ZERO;
         s2_sign <= 1'b0;
         s2_exp <= '0;
         s2_prod <= '0;
         s2_ca <= ZERO;
         s2_cb <= ZERO;
         out0 <= '0;
         flags <= '0;
      end else if (running) begin
         s1_sign <= a_sign ^ b_sign;
         s1_exp <= 10'(a_exp) + 10'(b_exp) - 10'(FP32_BIAS);
         s1_ma <= a_man;
         s1_mb <= b_man;
         s1_ca <= a_cls;
         s1_cb <= b_cls;
         s2_sign <= s1_sign;
         s2_exp <= s1_exp;
         s2_prod <= s1_ma * s1_mb;
         s2_ca <= s1_ca;
         s2_cb <= s1_cb;
         out0 <= res;
         flags <= flags | ev;
      end
   end
endmodule

// File: tb/tb_float_mul_pipe.sv
// tb_float_mul_pipe: directed-vector bench for float_mul_pipe covering products, rounding, specials, stalls and control.
module tb_float_mul_pipe;
   logic clk = 1'b0;
   logic rst, run, running;
   logic [31:0] in0, in1, out0;
   logic [2:0] flags;
   int total = 0;
   int bad = 0;

   float_mul_pipe #(.DATA_W(32), .LATENCY(3)) dut (
      .clk(clk), .rst(rst), .run(run), .running(running),
      .in0(in0), .in1(in1), .out0(out0), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic r, input logic rn, input logic ru, input logic [31:0] a, input logic [31:0] b);
      rst = r;
      run = rn;
      running = ru;
      in0 = a;
      in1 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      cyc(1, 0, 0, 32'h40000000, 32'h40000000);
      cyc(1, 0, 1, 32'h40000000, 32'h40000000);
      total++;
      if (out0 !== 32'h0) begin bad++; $display("FAIL reset_out0: got=%h want=%h", out0, 32'h0); end
      total++;
      if (flags !== 3'b000) begin bad++; $display("FAIL reset_flags: got=%b want=%b", flags, 3'b000); end
   endtask

   task automatic test_basic;
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 32'h40000000, 32'h40400000);
      cyc(0, 0, 1, 32'hC0000000, 32'h3F000000);
      total++;
      if (out0 !== 32'h0) begin bad++; $display("FAIL basic_early: got=%h want=%h", out0, 32'h0); end
      cyc(0, 0, 1, 0, 0);
      total++;
      if (out0 !== 32'h40C00000) begin bad++; $display("FAIL basic_2x3: got=%h want=%h", out0, 32'h40C00000); end
      cyc(0, 0, 1, 0, 0);
      total++;
      if (out0 !== 32'hBF800000) begin bad++; $display("FAIL basic_neg: got=%h want=%h", out0, 32'hBF800000); end
      total++;
      if (flags !== 3'b000) begin bad++; $display("FAIL basic_flags: got=%b want=%b", flags, 3'b000); end
   endtask

   task automatic test_rounding;
      logic [31:0] want;
`ifdef FLOAT_MUL_PIPE_RNE_EN
      want = 32'h40100002;
`else
      want = 32'h40100001;
`endif
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 32'h3FC00001, 32'h3FC00001);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      total++;
      if (out0 !== want) begin bad++; $display("FAIL rounding: got=%h want=%h", out0, want); end
      total++;
      if (flags !== 3'b000) begin bad++; $display("FAIL rounding_flags: got=%b want=%b", flags, 3'b000); end
   endtask

   task automatic test_specials;
      logic [31:0] sa [6] = '{32'h7F000000, 32'h00800000, 32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00001};
      logic [31:0] sb [6] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
      logic [31:0] so [6] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h7FC00000};
      logic [2:0]  sf [6] = '{3'b010, 3'b001, 3'b100, 3'b000, 3'b000, 3'b100};
      for (int i = 0; i < 6; i++) begin
         cyc(0, 1, 0, 0, 0);
         cyc(0, 0, 1, sa[i], sb[i]);
         cyc(0, 0, 1, 0, 0);
         cyc(0, 0, 1, 0, 0);
         total++;
         if (out0 !== so[i]) begin bad++; $display("FAIL special_out0[%0d]: got=%h want=%h", i, out0, so[i]); end
         total++;
         if (flags !== sf[i]) begin bad++; $display("FAIL special_flags[%0d]: got=%b want=%b", i, flags, sf[i]); end
      end
   endtask

   task automatic test_stall;
      logic        rp [10] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
      logic [31:0] pa [4] = '{32'h40000000, 32'hC0000000, 32'h3F800000, 32'h40400000};
      logic [31:0] pb [4] = '{32'h40400000, 32'h3F000000, 32'h3F800000, 32'h40400000};
      logic [31:0] eo [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h40C00000, 32'h40C00000,
                               32'hBF800000, 32'h3F800000, 32'h41100000, 32'h0};
      int k = 0;
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (rp[i]) begin
            cyc(0, 0, 1, k < 4 ? pa[k] : 32'h0, k < 4 ? pb[k] : 32'h0);
            k++;
         end else begin
            cyc(0, 0, 0, 32'h7FC00000, 32'h7FC00000);
         end
         total++;
         if (out0 !== eo[i]) begin bad++; $display("FAIL stall_out0[%0d]: got=%h want=%h", i, out0, eo[i]); end
      end
      total++;
      if (flags !== 3'b000) begin bad++; $display("FAIL stall_flags: got=%b want=%b", flags, 3'b000); end
   endtask

   task automatic test_run_mid;
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 32'h7F000000, 32'h7F000000);
      cyc(0, 0, 1, 32'h40000000, 32'h40400000);
      cyc(0, 0, 1, 32'h40400000, 32'h40400000);
      total++;
      if (out0 !== 32'h7F800000 || flags !== 3'b010) begin
         bad++; $display("FAIL run_pre: got=%h/%b want=%h/%b", out0, flags, 32'h7F800000, 3'b010);
      end
      cyc(0, 1, 1, 32'h40400000, 32'h40400000);
      total++;
      if (out0 !== 32'h0 || flags !== 3'b000) begin
         bad++; $display("FAIL run_clear: got=%h/%b want=%h/%b", out0, flags, 32'h0, 3'b000);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0, 0);
         total++;
         if (out0 !== 32'h0) begin bad++; $display("FAIL run_stale[%0d]: got=%h want=%h", i, out0, 32'h0); end
      end
   endtask

   task automatic test_rst_ctrl;
      for (int j = 0; j < 2; j++) begin
         cyc(0, 1, 0, 0, 0);
         cyc(0, 0, 1, 32'h7F000000, 32'h7F000000);
         cyc(0, 0, 1, 32'h40000000, 32'h40400000);
         cyc(0, 0, 1, 32'h40400000, 32'h40400000);
         cyc(1, j == 1, 1, 32'h3F800000, 32'h3F800000);
         total++;
         if (out0 !== 32'h0 || flags !== 3'b000) begin
            bad++; $display("FAIL rst_clear[%0d]: got=%h/%b want=%h/%b", j, out0, flags, 32'h0, 3'b000);
         end
         for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0);
            total++;
            if (out0 !== 32'h0) begin bad++; $display("FAIL rst_stale[%0d.%0d]: got=%h want=%h", j, i, out0, 32'h0); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_rounding;
      test_specials;
      test_stall;
      test_run_mid;
      test_rst_ctrl;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
